// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared state encoding and widths for the pipeline stage register
//   state_t : stage occupancy state, encoding doubles as the occupancy count
//   OCC_W   : width of the occupancy port
package pipe_stage_reg_pkg;
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;
   localparam int OCC_W = 2;
endpackage

// File: rtl/pipe_stage_reg_data.sv
// pipe_stage_reg_data: WIDTH-bit load-enabled payload register with async reset to RESET_VAL
//   clk, rst : clock, asynchronous active-high reset
//   en       : load enable
//   d, q     : payload in / registered payload out
module pipe_stage_reg_data #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= RESET_VAL;
      else if (en) q <= d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional 2-entry skid buffer and flush
//   clk, rst             : clock, asynchronous active-high reset
//   flush                : synchronous discard of all held entries
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload (registered)
//   occupancy            : number of entries held (0..2)
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter bit               SKID      = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [OCC_W-1:0] occupancy
);
   state_t           state, state_d;
   logic             acc_in, acc_out, load_main, load_skid;
   logic [WIDTH-1:0] main_d, skid_q;

   // With a skid entry, in_ready comes purely from the state register so the
   // downstream ready never reaches upstream combinationally.
   assign in_ready  = SKID ? (state != ST_SKID) : (state == ST_EMPTY || out_ready);
   assign out_valid = state != ST_EMPTY;
   assign occupancy = state;

   always_comb begin
      acc_in    = in_valid & in_ready;
      acc_out   = out_valid & out_ready;
      state_d   = flush ? ST_EMPTY :
                  state == ST_EMPTY ? (acc_in ? ST_FULL : ST_EMPTY) :
                  state == ST_FULL  ? ((acc_in && !acc_out) ? ST_SKID :
                                       (!acc_in && acc_out) ? ST_EMPTY : ST_FULL) :
                  (acc_out ? ST_FULL : ST_SKID);
      // Main only changes when empty or when its current value is being taken,
      // keeping the payload stable under backpressure.
      load_main = !flush && (state == ST_SKID ? acc_out : acc_in && (state == ST_EMPTY || acc_out));
      main_d    = state == ST_SKID ? skid_q : in_data;
      load_skid = !flush && state == ST_FULL && acc_in && !acc_out;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ST_EMPTY;
      else state <= state_d;

   pipe_stage_reg_data #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
      .clk (clk),
      .rst (rst),
      .en  (load_main),
      .d   (main_d),
      .q   (out_data)
   );

   generate
      if (SKID) begin : g_skid
         pipe_stage_reg_data #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
            .clk (clk),
            .rst (rst),
            .en  (load_skid),
            .d   (in_data),
            .q   (skid_q)
         );
      end else begin : g_noskid
         assign skid_q = RESET_VAL;
      end
   endgenerate
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed check of pipe_stage_reg (SKID=1 and SKID=0) against a FIFO model
module tb_pipe_stage_reg;
   localparam logic [31:0] RV = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fl[2];
   logic        iv[2];
   logic        ir[2];
   logic [31:0] id[2];
   logic        in_rdy[2];
   logic        ov[2];
   logic [31:0] od[2];
   logic [1:0]  occ[2];

   // model: up to two queued items per instance, plus the value out_data rests on when empty
   logic [31:0] mem[2][2];
   int          cnt[2];
   logic [31:0] hold[2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .RESET_VAL(RV)) dut0 (
      .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(in_rdy[0]), .in_data(id[0]),
      .out_valid(ov[0]), .out_ready(ir[0]), .out_data(od[0]), .occupancy(occ[0]));

   pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .RESET_VAL(RV)) dut1 (
      .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(in_rdy[1]), .in_data(id[1]),
      .out_valid(ov[1]), .out_ready(ir[1]), .out_data(od[1]), .occupancy(occ[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         cnt[k]  = 0;
         hold[k] = RV;
      end
   endtask

   task automatic drive(input int k, input logic v, input logic [31:0] d, input logic r, input logic f);
      iv[k] = v;
      id[k] = d;
      ir[k] = r;
      fl[k] = f;
   endtask

   task automatic drive_all(input logic v, input logic [31:0] d, input logic r, input logic f);
      drive(0, v, d, r, f);
      drive(1, v, d, r, f);
   endtask

   // Called just after a negedge with inputs applied: check, advance the model, move to next negedge.
   task automatic tick();
      logic rdy, ai, ao;
      #1;
      for (int k = 0; k < 2; k++) begin
         rdy = (k == 0) ? (cnt[k] < 2) : (cnt[k] == 0 || ir[k]);
         chk($sformatf("d%0d in_ready", k), {31'b0, in_rdy[k]}, {31'b0, rdy});
         chk($sformatf("d%0d out_valid", k), {31'b0, ov[k]}, {31'b0, cnt[k] > 0});
         chk($sformatf("d%0d occupancy", k), {30'b0, occ[k]}, cnt[k]);
         chk($sformatf("d%0d out_data", k), od[k], cnt[k] > 0 ? mem[k][0] : hold[k]);
         ai = iv[k] & rdy;
         ao = (cnt[k] > 0) & ir[k];
         if (cnt[k] > 0) hold[k] = mem[k][0];
         if (fl[k]) cnt[k] = 0;
         else begin
            if (ao) begin
               mem[k][0] = mem[k][1];
               cnt[k]--;
            end
            if (ai) begin
               mem[k][cnt[k]] = id[k];
               cnt[k]++;
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      drive_all(1'b0, 32'h0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tick();
      // streaming with downstream always ready
      for (int i = 1; i <= 8; i++) begin
         drive_all(1'b1, i, 1'b1, 1'b0);
         tick();
      end
      drive_all(1'b0, 32'h0, 1'b1, 1'b0);
      repeat (2) tick();
      // backpressure: SKID=1 fills both entries, SKID=0 refuses the second push
      drive_all(1'b1, 32'h11, 1'b0, 1'b0); tick();
      drive_all(1'b1, 32'h22, 1'b0, 1'b0); tick();
      drive_all(1'b0, 32'h0, 1'b0, 1'b0); tick();
      drive_all(1'b1, 32'h44, 1'b1, 1'b0); tick();
      drive_all(1'b0, 32'h0, 1'b1, 1'b0);
      repeat (3) tick();
      // flush while full; the item offered with the flush must vanish
      drive_all(1'b1, 32'h0A, 1'b0, 1'b0); tick();
      drive_all(1'b1, 32'h0B, 1'b0, 1'b0); tick();
      drive_all(1'b1, 32'h33, 1'b0, 1'b1); tick();
      drive_all(1'b0, 32'h0, 1'b1, 1'b0);
      repeat (2) tick();
      // async reset in the middle of a cycle while holding items
      drive_all(1'b1, 32'h0A, 1'b0, 1'b0); tick();
      drive_all(1'b1, 32'h0B, 1'b0, 1'b0); tick();
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d rst out_valid", k), {31'b0, ov[k]}, 32'd0);
         chk($sformatf("d%0d rst out_data", k), od[k], RV);
         chk($sformatf("d%0d rst occupancy", k), {30'b0, occ[k]}, 32'd0);
      end
      model_reset();
      drive_all(1'b1, 32'h55, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      drive_all(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      // random valid/ready/flush, independent per instance
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < 2; k++)
            drive(k, 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 31) == 0));
         tick();
      end
      drive_all(1'b0, 32'h0, 1'b1, 1'b0);
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
